// File: rtl/mc_control_unit_pkg.sv
// Shared encodings for the multi-cycle control unit:
// opcodes, functs, ALU ops, PC selects, state codes.
package mc_control_unit_pkg;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_AL = 4'd2,
    S_WB_AL  = 4'd3,
    S_EXE_LS = 4'd4,
    S_MEM    = 4'd5,
    S_WB_LD  = 4'd6,
    S_EXE_BR = 4'd7,
    S_HALT   = 4'd8,
    S_ERR    = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  localparam logic FROM_RT   = 1'b0;
  localparam logic FROM_RD   = 1'b1;
  localparam logic FROM_ALU  = 1'b0;
  localparam logic FROM_DATA = 1'b1;

  function automatic logic legal_func(input logic [5:0] f);
    return (f == F_ADD) || (f == F_SUB) ||
           (f == F_AND) || (f == F_OR) ||
           (f == F_SLT) || (f == F_SLL);
  endfunction

endpackage

// File: rtl/mc_control_unit_watchdog.sv
// Memory watchdog: flags a request left unacknowledged
// for MEM_TIMEOUT consecutive cycles.
module mc_mem_watchdog #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic RST,
  input  logic req,
  input  logic ack,
  output logic timeout
);

  logic [7:0] cnt;

  // count consecutive waiting cycles, clear on ack or idle
  always_ff @(posedge clk) begin
    if (!RST || !req || ack) cnt <= '0;
    else                     cnt <= cnt + 8'd1;
  end

  assign timeout = req && !ack &&
                   (cnt == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control unit, IF/ID/EXE/MEM/WB sequencer.
// PERF_CNT_EN builds the retired-instruction counter.
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int FUNC_W      = 6,
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNC_W-1:0]  func,
  input  logic               ZERO,
  input  logic               SIGN,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_sel,
  output logic               IRWr,
  output logic               PCWr,
  output logic [1:0]         PCSel,
  output logic               ALUScrA,
  output logic               ALUScrB,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               ExtSel,
  output logic               RegDst,
  output logic               DB,
  output logic               RegWr,
  output logic               halted,
  output logic               err,
  output logic [CNT_W-1:0]   retired,
  output logic [3:0]         state
);

  state_t cur, nxt;
  logic   timeout;
  logic   r_ok, is_imm, is_alu, is_ls, is_sw, is_br;
  logic   taken;
  logic [2:0] al_op;
  logic   al_a, al_b, al_ext, al_dst;

  mc_mem_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wd (
    .clk    (clk),
    .RST    (RST),
    .req    (mem_req),
    .ack    (mem_ack),
    .timeout(timeout)
  );

  assign r_ok   = (op == OP_RTYPE) && legal_func(func);
  assign is_imm = (op == OP_ADDIU) || (op == OP_ANDI) ||
                  (op == OP_ORI);
  assign is_alu = r_ok || is_imm;
  assign is_sw  = (op == OP_SW);
  assign is_ls  = (op == OP_LW) || is_sw;
  assign is_br  = (op == OP_BEQ) || (op == OP_BNE) ||
                  (op == OP_BLTZ);
  assign taken  = ((op == OP_BEQ) && ZERO) ||
                  ((op == OP_BNE) && !ZERO) ||
                  ((op == OP_BLTZ) && SIGN);
  assign state  = cur;

  // state register
  always_ff @(posedge clk) begin
    if (!RST) cur <= S_IF;
    else      cur <= nxt;
  end

  // next-state sequencing
  always_comb begin
    nxt = cur;
    unique case (cur)
      S_IF: begin
        if (timeout)      nxt = S_ERR;
        else if (mem_ack) nxt = S_ID;
      end
      S_ID: begin
        unique case (1'b1)
          op == OP_J:    nxt = S_IF;
          op == OP_HALT: nxt = S_HALT;
          is_alu:        nxt = S_EXE_AL;
          is_ls:         nxt = S_EXE_LS;
          is_br:         nxt = S_EXE_BR;
          default:       nxt = S_ERR;
        endcase
      end
      S_EXE_AL: nxt = S_WB_AL;
      S_WB_AL:  nxt = S_IF;
      S_EXE_LS: nxt = S_MEM;
      S_MEM: begin
        if (timeout)      nxt = S_ERR;
        else if (mem_ack) nxt = is_sw ? S_IF : S_WB_LD;
      end
      S_WB_LD:  nxt = S_IF;
      S_EXE_BR: nxt = S_IF;
      S_HALT:   nxt = S_HALT;
      S_ERR:    nxt = S_ERR;
      default:  nxt = S_ERR;
    endcase
  end

  // ALU operand/op selection for register and immediate ops
  always_comb begin
    al_op  = ALU_ADD;
    al_a   = 1'b0;
    al_b   = 1'b0;
    al_ext = 1'b0;
    al_dst = FROM_RT;
    if (op == OP_RTYPE) begin
      al_dst = FROM_RD;
      unique case (func)
        F_SUB:   al_op = ALU_SUB;
        F_AND:   al_op = ALU_AND;
        F_OR:    al_op = ALU_OR;
        F_SLT:   al_op = ALU_SLT;
        F_SLL: begin
          al_op = ALU_SLL;
          al_a  = 1'b1;
        end
        default: al_op = ALU_ADD;
      endcase
    end else begin
      al_b = 1'b1;
      unique case (op)
        OP_ANDI: al_op = ALU_AND;
        OP_ORI:  al_op = ALU_OR;
        default: begin
          al_op  = ALU_ADD;
          al_ext = 1'b1;
        end
      endcase
    end
  end

  // datapath controls decoded from state and instruction
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    mem_sel = 1'b0;
    IRWr    = 1'b0;
    PCWr    = 1'b0;
    PCSel   = PC_SEQ;
    ALUScrA = 1'b0;
    ALUScrB = 1'b0;
    ALUop   = ALU_ADD;
    ExtSel  = 1'b0;
    RegDst  = FROM_RT;
    DB      = FROM_ALU;
    RegWr   = 1'b0;
    halted  = 1'b0;
    err     = 1'b0;
    if (RST) begin
      unique case (cur)
        S_IF: begin
          mem_req = 1'b1;
          IRWr    = mem_ack;
        end
        S_ID: begin
          if (op == OP_J) begin
            PCWr  = 1'b1;
            PCSel = PC_JMP;
          end
        end
        S_EXE_AL, S_WB_AL: begin
          ALUScrA = al_a;
          ALUScrB = al_b;
          ALUop   = al_op;
          ExtSel  = al_ext;
          RegDst  = al_dst;
          RegWr   = (cur == S_WB_AL);
          PCWr    = (cur == S_WB_AL);
        end
        S_EXE_LS, S_MEM, S_WB_LD: begin
          ALUScrB = 1'b1;
          ExtSel  = 1'b1;
          if (cur == S_MEM) begin
            mem_req = 1'b1;
            mem_sel = 1'b1;
            mem_we  = is_sw;
            PCWr    = is_sw && mem_ack;
          end
          if (cur == S_WB_LD) begin
            DB    = FROM_DATA;
            RegWr = 1'b1;
            PCWr  = 1'b1;
          end
        end
        S_EXE_BR: begin
          ALUop  = (op == OP_BLTZ) ? ALU_ADD : ALU_SUB;
          ExtSel = 1'b1;
          PCWr   = 1'b1;
          PCSel  = taken ? PC_BR : PC_SEQ;
        end
        S_HALT:  halted = 1'b1;
        S_ERR:   err = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic             retire;
  logic [CNT_W-1:0] ret_cnt;

  assign retire = ((cur == S_ID) && (op == OP_J)) ||
                  (cur == S_WB_AL) || (cur == S_WB_LD) ||
                  (cur == S_EXE_BR) ||
                  ((cur == S_MEM) && is_sw && mem_ack);

  // retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (!RST)        ret_cnt <= '0;
    else if (retire) ret_cnt <= ret_cnt + 1'b1;
  end

  assign retired = ret_cnt;
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized bench for mc_control_unit against a
// per-instruction signature model.
module tb_mc_control_unit;

  localparam int TMO = 16;
  localparam int CW  = 4;

  localparam int K_ALU  = 0;
  localparam int K_LW   = 1;
  localparam int K_SW   = 2;
  localparam int K_BR   = 3;
  localparam int K_J    = 4;
  localparam int K_HALT = 5;
  localparam int K_ILL  = 6;

  logic          clk = 1'b0;
  logic          RST = 1'b0;
  logic [5:0]    op = '0;
  logic [5:0]    func = '0;
  logic          ZERO = 1'b0;
  logic          SIGN = 1'b0;
  logic          mem_ack = 1'b0;
  logic          mem_req, mem_we, mem_sel, IRWr, PCWr;
  logic [1:0]    PCSel;
  logic          ALUScrA, ALUScrB, ExtSel, RegDst, DB, RegWr;
  logic [2:0]    ALUop;
  logic          halted, err;
  logic [CW-1:0] retired;
  logic [3:0]    state;

  int n_chk = 0;
  int n_fail = 0;
  int model_ret = 0;

  always #5 clk = ~clk;

  mc_control_unit #(
    .MEM_TIMEOUT(TMO),
    .CNT_W      (CW)
  ) dut (
    .clk    (clk),
    .RST    (RST),
    .op     (op),
    .func   (func),
    .ZERO   (ZERO),
    .SIGN   (SIGN),
    .mem_ack(mem_ack),
    .mem_req(mem_req),
    .mem_we (mem_we),
    .mem_sel(mem_sel),
    .IRWr   (IRWr),
    .PCWr   (PCWr),
    .PCSel  (PCSel),
    .ALUScrA(ALUScrA),
    .ALUScrB(ALUScrB),
    .ALUop  (ALUop),
    .ExtSel (ExtSel),
    .RegDst (RegDst),
    .DB     (DB),
    .RegWr  (RegWr),
    .halted (halted),
    .err    (err),
    .retired(retired),
    .state  (state)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_ret();
`ifdef PERF_CNT_EN
    return 32'(model_ret % (1 << CW));
`else
    return 32'd0;
`endif
  endfunction

  function automatic int kind_of(input logic [5:0] o,
                                 input logic [5:0] f);
    case (o)
      6'b000000:
        return (f inside {6'b100000, 6'b100010,
                          6'b100100, 6'b100101,
                          6'b101010, 6'b000000})
               ? K_ALU : K_ILL;
      6'b001001, 6'b001100, 6'b001101: return K_ALU;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100, 6'b000101, 6'b000001: return K_BR;
      6'b000010: return K_J;
      6'b111111: return K_HALT;
      default:   return K_ILL;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    RST = 1'b0;
    mem_ack = 1'b0;
    @(posedge clk);
    #1;
    check("rst_state", state, 0);
    check("rst_req", mem_req, 0);
    check("rst_en", {mem_we, IRWr, PCWr, RegWr}, 0);
    check("rst_sel", {mem_sel, PCSel, ALUScrA, ALUScrB,
                      ALUop, ExtSel, RegDst, DB}, 0);
    check("rst_flags", {halted, err}, 0);
    check("rst_retired", retired, 0);
    model_ret = 0;
    @(negedge clk);
    RST = 1'b1;
  endtask

  task automatic step(input logic [5:0] o,
                      input logic [5:0] f,
                      input int lif,
                      input int lmem,
                      input logic z,
                      input logic s);
    int k, ecyc, epc, ereg, emsel;
    int cyc, w, irwr_n, pcwr_n, regwr_n, msel_n, mwe_n;
    bit iferr, memerr, ehalt, eerr, tk, done;
    logic [1:0] epcsel, pcsel_v;
    logic [2:0] eop, aop;
    logic ea, eb, eext, edst;
    logic aa, ab, ext, rdst_v, db_v;
    logic [3:0] prev;

    k = kind_of(o, f);
    iferr  = lif >= TMO;
    memerr = !iferr && (k == K_LW || k == K_SW) &&
             lmem >= TMO;
    ecyc = iferr ? TMO : lif + 1;
    if (!iferr) begin
      case (k)
        K_ALU:            ecyc += 3;
        K_BR:             ecyc += 2;
        K_J, K_HALT, K_ILL: ecyc += 1;
        default: ecyc += 2 + (memerr ? TMO : lmem + 1) +
                         (k == K_LW ? 1 : 0);
      endcase
    end
    epc = (!iferr && !memerr &&
           k inside {K_ALU, K_LW, K_SW, K_BR, K_J}) ? 1 : 0;
    ereg = (epc == 1 && k inside {K_ALU, K_LW}) ? 1 : 0;
    emsel = (!iferr && k inside {K_LW, K_SW})
            ? (memerr ? TMO : lmem + 1) : 0;
    ehalt = !iferr && k == K_HALT;
    eerr  = iferr || memerr || k == K_ILL;
    tk = (o == 6'b000100 && z) || (o == 6'b000101 && !z) ||
         (o == 6'b000001 && s);
    epcsel = (k == K_J) ? 2'b10 :
             (k == K_BR && tk) ? 2'b01 : 2'b00;

    ea = 0; eb = 0; eext = 0; edst = 0; eop = 3'd0;
    case (o)
      6'b000000: begin
        edst = 1;
        case (f)
          6'b100010: eop = 3'd1;
          6'b100100: eop = 3'd4;
          6'b100101: eop = 3'd3;
          6'b101010: eop = 3'd5;
          6'b000000: begin eop = 3'd2; ea = 1; end
          default:   eop = 3'd0;
        endcase
      end
      6'b001001: begin eb = 1; eext = 1; end
      6'b001100: begin eb = 1; eop = 3'd4; end
      6'b001101: begin eb = 1; eop = 3'd3; end
      6'b100011, 6'b101011: begin eb = 1; eext = 1; end
      6'b000100, 6'b000101: eop = 3'd1;
      default: eop = 3'd0;
    endcase

    op = o; func = f; ZERO = z; SIGN = s;
    cyc = 0; w = 0; irwr_n = 0; pcwr_n = 0; regwr_n = 0;
    msel_n = 0; mwe_n = 0; done = 0; pcsel_v = 0;
    rdst_v = 0; db_v = 0; aop = 0; aa = 0; ab = 0; ext = 0;
    prev = 0;
    while (!done && cyc < 200) begin
      #1;
      if (mem_req) begin
        mem_ack = (w >= (mem_sel ? lmem : lif));
        w = mem_ack ? 0 : w + 1;
      end else begin
        mem_ack = 1'b0;
        w = 0;
      end
      #1;
      cyc++;
      if (IRWr) irwr_n++;
      if (PCWr) begin pcwr_n++; pcsel_v = PCSel; end
      if (RegWr) begin
        regwr_n++; rdst_v = RegDst; db_v = DB;
      end
      if (mem_sel) msel_n++;
      if (mem_we) mwe_n++;
      if (state inside {4'd2, 4'd4, 4'd7}) begin
        aop = ALUop; aa = ALUScrA; ab = ALUScrB; ext = ExtSel;
      end
      prev = state;
      @(posedge clk);
      #1;
      if ((state == 4'd0 && prev != 4'd0) ||
          state == 4'd8 || state == 4'd9) done = 1;
      @(negedge clk);
    end
    mem_ack = 1'b0;

    check("bound", done, 1);
    check("cycles", cyc, ecyc);
    check("irwr", irwr_n, iferr ? 0 : 1);
    check("pcwr", pcwr_n, epc);
    check("regwr", regwr_n, ereg);
    check("memsel", msel_n, emsel);
    check("memwe", mwe_n, k == K_SW ? emsel : 0);
    check("halted", halted, ehalt);
    check("err", err, eerr);
    if (epc == 1) check("pcsel", pcsel_v, epcsel);
    if (ereg == 1) begin
      check("regdst", rdst_v, k == K_LW ? 1'b0 : edst);
      check("db", db_v, k == K_LW);
    end
    if (!iferr && k inside {K_ALU, K_LW, K_SW, K_BR}) begin
      check("aluop", aop, eop);
      check("alua", aa, ea);
      check("alub", ab, eb);
      if (k != K_BR) check("extsel", ext, eext);
    end
    model_ret += epc;
    check("retired", retired, exp_ret());

    if (ehalt || eerr) begin
      for (int i = 0; i < 3; i++) begin
        mem_ack = 1'b1;
        #1;
        check("term_req", mem_req, 0);
        check("term_en", {PCWr, RegWr, IRWr, mem_we}, 0);
        check("term_state", state, ehalt ? 9'd8 : 9'd9);
        check("term_retired", retired, exp_ret());
        @(negedge clk);
      end
      mem_ack = 1'b0;
      do_reset();
    end
  endtask

  logic [5:0] tbl_op [18];
  logic [5:0] tbl_fn [18];

  initial begin
    tbl_op = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
               6'h09, 6'h0c, 6'h0d, 6'h23, 6'h2b, 6'h04,
               6'h05, 6'h01, 6'h02, 6'h3f, 6'h10, 6'h00};
    tbl_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00,
               6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
               6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h3f};

    do_reset();
    step(6'h00, 6'h20, 0, 0, 0, 0);
    step(6'h23, 6'h00, 3, 3, 0, 0);
    step(6'h04, 6'h00, 0, 0, 1, 0);
    step(6'h04, 6'h00, 0, 0, 0, 0);
    step(6'h01, 6'h00, 0, 0, 0, 1);
    step(6'h2b, 6'h00, 1, 2, 0, 0);
    step(6'h00, 6'h20, 40, 0, 0, 0);
    step(6'h2b, 6'h00, 0, 40, 0, 0);
    step(6'h3f, 6'h00, 0, 0, 0, 0);
    step(6'h10, 6'h00, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++)
      step(6'h02, 6'h00, 0, 0, 0, 0);

    for (int n = 0; n < 250; n++) begin
      int idx, lif, lmem;
      idx = ($urandom_range(0, 39) == 0)
            ? int'($urandom_range(15, 17))
            : int'($urandom_range(0, 14));
      lif  = ($urandom_range(0, 29) == 0)
             ? 20 : int'($urandom_range(0, 3));
      lmem = ($urandom_range(0, 29) == 0)
             ? 20 : int'($urandom_range(0, 3));
      step(tbl_op[idx], tbl_fn[idx], lif, lmem,
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
